p2_dec: RTL and testbench

P2_DEC -- requirements
Module: p2_dec

---
 rtl/p2_dec.sv | 90 +++++++++
 tb/tb_p2_dec.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/p2_dec.sv
// Recovers x bits from p2 encoder state words and packs them MSB-first into BYTE_W words.
// Latency 1 cycle (all outputs registered); no backpressure, every en=1 sample is consumed.
module p2_dec #(
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        a,
    input  logic              en,
    output logic              x_out,
    output logic              x_vld,
    output logic              err,
    output logic [BYTE_W-1:0] word_out,
    output logic              word_vld,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BC_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [BC_W-1:0] LAST = BC_W'(BYTE_W - 1);

    logic [1:0]        pa;
    logic              have_prev;
    logic [BC_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] sh_next;
    logic              is_one;
    logic              is_zero;
    logic              is_amb;
    logic              is_ill;

    always_comb begin
        is_one  = 1'b0;
        is_zero = 1'b0;
        is_amb  = 1'b0;
        case ({pa, a})
            4'b0000, 4'b1010, 4'b1111: is_one  = 1'b1;
            4'b0001, 4'b1001, 4'b1101: is_zero = 1'b1;
            4'b0110:                   is_amb  = 1'b1;
            default:                   ;
        endcase
        is_ill  = !(is_one || is_zero || is_amb);
        sh_next = {shreg[BYTE_W-2:0], is_one};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pa        <= 2'b00;
            have_prev <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            x_out     <= 1'b0;
            x_vld     <= 1'b0;
            err       <= 1'b0;
            word_out  <= '0;
            word_vld  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            x_vld    <= 1'b0;
            err      <= 1'b0;
            word_vld <= 1'b0;
            if (en) begin
                pa        <= a;
                have_prev <= 1'b1;
                if (have_prev) begin
                    if (is_one || is_zero) begin
                        x_out <= is_one;
                        x_vld <= 1'b1;
                        shreg <= sh_next;
                        if (bit_cnt == LAST) begin
                            word_out <= sh_next;
                            word_vld <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (is_ill) begin
                        // partial word is dropped so the next word starts clean
                        err     <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_p2_dec.sv
// Randomized bench for p2_dec with a transition-table / bit-queue reference model.
// Directed scenarios pin the model with literal expectations.
module tb_p2_dec;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a;
    logic       en;
    logic       x_out, x_vld, err, word_vld;
    logic [7:0] word_out;
    logic [3:0] err_cnt;

    p2_dec #(.BYTE_W(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .a(a), .en(en),
        .x_out(x_out), .x_vld(x_vld), .err(err),
        .word_out(word_out), .word_vld(word_vld), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // transition kind: 0/1 = decoded bit, 2 = ambiguous, 3 = illegal
    int   tbl [16];
    logic m_have;
    logic [1:0] m_prev;
    bit   q [$];
    logic exp_x, exp_xv, exp_err, exp_wv;
    logic [7:0] exp_word;
    int   exp_cnt;
    logic [1:0] cur;
    bit   chk_on = 1'b0;
    bit   gaps   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0; m_prev = 2'b00; q.delete();
        exp_x = 0; exp_xv = 0; exp_err = 0; exp_wv = 0; exp_word = 0; exp_cnt = 0;
    endtask

    task automatic model_step(input logic e, input logic [1:0] aa);
        int kind;
        exp_xv = 0; exp_err = 0; exp_wv = 0;
        if (!e) return;
        if (!m_have) begin
            m_have = 1'b1; m_prev = aa; return;
        end
        kind = tbl[{m_prev, aa}];
        m_prev = aa;
        if (kind <= 1) begin
            exp_x = kind[0]; exp_xv = 1;
            q.push_back(kind[0]);
            if (q.size() == 8) begin
                exp_word = 0;
                foreach (q[i]) exp_word = {exp_word[6:0], q[i]};
                exp_wv = 1;
                q.delete();
            end
        end else if (kind == 3) begin
            exp_err = 1;
            q.delete();
            if (exp_cnt < 15) exp_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("x_vld", x_vld, exp_xv);
            check("x_out", x_out, exp_x);
            check("err", err, exp_err);
            check("word_vld", word_vld, exp_wv);
            check("word_out", word_out, exp_word);
            check("err_cnt", err_cnt, exp_cnt);
        end
    end

    task automatic drive(input logic e, input logic [1:0] aa);
        en = e; a = aa;
        @(posedge clk);
        model_step(e, aa);
        if (e) cur = aa;
        #1;
    endtask

    task automatic step(input logic [1:0] aa);
        if (gaps && $urandom_range(0, 2) == 0) drive(1'b0, 2'($urandom));
        drive(1'b1, aa);
    endtask

    task automatic send_bit(input bit b);
        if (cur == 2'b01) step(2'b10);
        if (b) step(cur);
        else   step(2'b01);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cur = 2'b00;
    endtask

    initial begin
        logic [7:0] pat;
        foreach (tbl[i]) tbl[i] = 3;
        tbl[4'b0000] = 1; tbl[4'b1010] = 1; tbl[4'b1111] = 1;
        tbl[4'b0001] = 0; tbl[4'b1001] = 0; tbl[4'b1101] = 0;
        tbl[4'b0110] = 2;
        reset = 1'b0; en = 1'b0; a = 2'b00; cur = 2'b00;
        model_reset();
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_word", word_out, 8'h00);
        check("reset_cnt", err_cnt, 4'd0);
        reset = 1'b1;

        // basic decode sequence 00,00,01,10,01
        drive(1, 2'b00); check("first_no_xvld", x_vld, 1'b0);
        drive(1, 2'b00); check("d1_vld", x_vld, 1'b1); check("d1_x", x_out, 1'b1);
        drive(1, 2'b01); check("d2_vld", x_vld, 1'b1); check("d2_x", x_out, 1'b0);
        drive(1, 2'b10); check("amb_vld", x_vld, 1'b0); check("amb_err", err, 1'b0);
        drive(1, 2'b01); check("d3_vld", x_vld, 1'b1); check("d3_x", x_out, 1'b0);

        // word 1,0,1,1,0,0,1,0 -> B2
        do_reset();
        drive(1, 2'b00);
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i > 0) check("no_early_wvld", word_vld, 1'b0);
        end
        check("b2_word", word_out, 8'hB2);
        check("b2_wvld", word_vld, 1'b1);
        check("b2_xvld", x_vld, 1'b1);

        // partial word then illegal 00->11, then fresh word
        do_reset();
        drive(1, 2'b00);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        drive(1, 2'b11);
        check("ill_err", err, 1'b1);
        check("ill_cnt", err_cnt, 4'd1);
        check("ill_word_hold", word_out, 8'h00);
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        check("a5_word", word_out, 8'hA5);

        // saturation
        do_reset();
        drive(1, 2'b00);
        for (int i = 0; i < 20; i++) drive(1, (i % 2 == 0) ? 2'b10 : 2'b00);
        check("sat_cnt", err_cnt, 4'd15);

        // en gaps on a legal stream
        do_reset();
        gaps = 1'b1;
        drive(1, 2'b00);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom));
        gaps = 1'b0;

        // async reset mid-word
        do_reset();
        drive(1, 2'b00);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_x", x_out, 1'b0);
        check("arst_xvld", x_vld, 1'b0);
        check("arst_word", word_out, 8'h00);
        check("arst_cnt", err_cnt, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 2'b00);
        check("post_rst_xvld", x_vld, 1'b0);
        check("post_rst_err", err, 1'b0);

        // randomized mix
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: drive(1'($urandom), 2'($urandom));
                9:       if ($urandom_range(0, 9) == 0) do_reset();
                         else send_bit(1'($urandom));
                default: begin
                    gaps = 1'($urandom);
                    send_bit(1'($urandom));
                end
            endcase
        end
        gaps = 1'b0;
        drive(0, 2'b00);
        drive(0, 2'b00);

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
